// File: rtl/vga_board_capture.sv
// vga_board_capture
//   Sink end of the gol VGA display path. Samples the centre pixel of every
//   cell on the pixel clock, rebuilds the HEIGHT x WIDTH board bitmap in a
//   shadow register, and publishes it on board_out once per complete,
//   well-formed frame.
//
// Ports
//   clk          pixel clock (same as the gol vga_clk)
//   reset        asynchronous, active-high
//   r, g, b      8-bit pixel colour; only g drives the alive decision
//   hsync_out    horizontal sync, active-low
//   vsync_out    vertical sync, active-low
//   vga_blank    1 = visible pixel (BLANK_N convention)
//   board_out    last good captured board, [row][col]
//   frame_valid  one-cycle pulse when board_out updates
//   frame_err    one-cycle pulse when a frame is rejected
//
// Optional build macro CAPTURE_STATS_EN adds:
//   alive_count   popcount of board_out, updated with board_out
//   board_changed high for the frame_valid cycle if the board differs from
//                 the previous board_out
module vga_board_capture #(
  parameter int HEIGHT   = 20,
  parameter int WIDTH    = 20,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CELL_W   = 32,
  parameter int CELL_H   = 24,
  parameter int THRESH   = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [7:0]                     r,
  input  logic [7:0]                     g,
  input  logic [7:0]                     b,
  input  logic                           hsync_out,
  input  logic                           vsync_out,
  input  logic                           vga_blank,
  output logic [0:HEIGHT-1][0:WIDTH-1]   board_out,
  output logic                           frame_valid,
`ifdef CAPTURE_STATS_EN
  output logic                           frame_err,
  output logic [$clog2(HEIGHT*WIDTH+1)-1:0] alive_count,
  output logic                           board_changed
`else
  output logic                           frame_err
`endif
);

  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 2);
  localparam logic [XW-1:0] X_SAT = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_SAT = YW'(V_ACTIVE + 1);

  typedef enum logic {SYNC, FRAME} state_t;
  typedef logic [0:HEIGHT-1][0:WIDTH-1] board_t;

  state_t          state_q, state_d;
  logic            vs_q, vs_prev_q, hs_q, hs_prev_q, blank_q;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            line_bad_q, line_bad_d;
  board_t          shadow_q, shadow_d, board_q, board_d;
  logic            valid_q, valid_d, err_q, err_d;
  board_t          hit;
  logic            vs_fall, hs_fall, blank_fall, alive_px;

  // Red and blue carry no information for the alive decision.
  logic unused_rb;
  assign unused_rb = ^{r, b};

  assign vs_fall    = vs_prev_q & ~vs_q;
  assign hs_fall    = hs_prev_q & ~hs_q;
  assign blank_fall = blank_q & ~vga_blank;
  assign alive_px   = (g >= 8'(THRESH));

  // One-hot map of the cell whose centre is at the current (x, y).
  for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
    for (genvar gj = 0; gj < WIDTH; gj++) begin : g_col
      assign hit[gi][gj] = (y_q == YW'(gi * CELL_H + CELL_H / 2)) &&
                           (x_q == XW'(gj * CELL_W + CELL_W / 2));
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    line_bad_d = line_bad_q;
    shadow_d   = shadow_q;
    board_d    = board_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      SYNC: begin
        if (vs_fall) begin
          state_d    = FRAME;
          x_d        = '0;
          y_d        = '0;
          line_bad_d = 1'b0;
          shadow_d   = '0;
        end
      end
      FRAME: begin
        if (vga_blank) begin
          shadow_d = (shadow_q & ~hit) | (hit & {(HEIGHT*WIDTH){alive_px}});
          if (x_q != X_SAT) x_d = x_q + 1'b1;
          // Visible pixels during vertical sync mean broken timing.
          if (!vsync_out) line_bad_d = 1'b1;
          if (hs_fall)    line_bad_d = 1'b1;
        end
        // Close the line before any frame evaluation in the same cycle.
        if (blank_fall) begin
          if (x_q != XW'(H_ACTIVE)) line_bad_d = 1'b1;
          x_d = '0;
          if (y_q != Y_SAT) y_d = y_q + 1'b1;
        end
        if (vs_fall) begin
          if ((y_d == YW'(V_ACTIVE)) && !line_bad_d) begin
            board_d = shadow_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          x_d        = '0;
          y_d        = '0;
          line_bad_d = 1'b0;
          shadow_d   = '0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= SYNC;
      vs_q       <= 1'b1;
      vs_prev_q  <= 1'b1;
      hs_q       <= 1'b1;
      hs_prev_q  <= 1'b1;
      blank_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      line_bad_q <= 1'b0;
      shadow_q   <= '0;
      board_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vsync_out;
      vs_prev_q  <= vs_q;
      hs_q       <= hsync_out;
      hs_prev_q  <= hs_q;
      blank_q    <= vga_blank;
      x_q        <= x_d;
      y_q        <= y_d;
      line_bad_q <= line_bad_d;
      shadow_q   <= shadow_d;
      board_q    <= board_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign board_out   = board_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;

`ifdef CAPTURE_STATS_EN
  localparam int CNT_W = $clog2(HEIGHT * WIDTH + 1);
  logic [CNT_W-1:0] alive_q, alive_d;
  logic             changed_q, changed_d;

  always_comb begin
    alive_d   = alive_q;
    changed_d = 1'b0;
    if (valid_d) begin
      alive_d = '0;
      for (int rr = 0; rr < HEIGHT; rr++) begin
        for (int c = 0; c < WIDTH; c++) begin
          alive_d = alive_d + CNT_W'(shadow_q[rr][c]);
        end
      end
      // board_q is zero after reset, so a first nonzero frame reads as changed.
      changed_d = (shadow_q != board_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      alive_q   <= alive_d;
      changed_q <= changed_d;
    end
  end

  assign alive_count   = alive_q;
  assign board_changed = changed_q;
`endif

endmodule
